// File: rtl/cve2_hpm_counter_unit_pkg.sv
// Shared constants, event encodings and CSR numbers for the machine counter/timer unit.
// Helper functions derive the writable mcountinhibit bits and the implemented counter indices.
package cve2_hpm_counter_unit_pkg;

    localparam int unsigned CSR_MHPM_FIRST_IDX    = 3;
    localparam int unsigned CSR_MHPM_MAX_COUNTERS = 29;

    typedef enum logic [4:0] {
        HPM_EVT_LOAD         = 5'd0,
        HPM_EVT_STORE        = 5'd1,
        HPM_EVT_JUMP         = 5'd2,
        HPM_EVT_BRANCH       = 5'd3,
        HPM_EVT_BRANCH_TAKEN = 5'd4,
        HPM_EVT_COMPRESSED   = 5'd5,
        HPM_EVT_MUL_WAIT     = 5'd6,
        HPM_EVT_DIV_WAIT     = 5'd7,
        HPM_EVT_LSU_WAIT     = 5'd8,
        HPM_EVT_IFETCH_WAIT  = 5'd9
    } hpm_event_e;

    typedef enum logic [11:0] {
        CSR_MCOUNTINHIBIT  = 12'h320,
        CSR_MHPMEVENT3     = 12'h323,
        CSR_MHPMEVENT31    = 12'h33F,
        CSR_MCYCLE         = 12'hB00,
        CSR_MINSTRET       = 12'hB02,
        CSR_MHPMCOUNTER3   = 12'hB03,
        CSR_MHPMCOUNTER31  = 12'hB1F,
        CSR_MCYCLEH        = 12'hB80,
        CSR_MINSTRETH      = 12'hB82,
        CSR_MHPMCOUNTER3H  = 12'hB83,
        CSR_MHPMCOUNTER31H = 12'hB9F
    } csr_num_e;

    // Upper seven address bits of the three 32-entry pages this unit owns.
    localparam logic [6:0] CSR_PAGE_EVT    = 7'h19;
    localparam logic [6:0] CSR_PAGE_CNT_LO = 7'h58;
    localparam logic [6:0] CSR_PAGE_CNT_HI = 7'h5C;

    function automatic logic [31:0] inhibit_mask(input int unsigned num_counters);
        logic [31:0] mask;
        mask = 32'h0000_0005;
        for (int unsigned k = 0; k < CSR_MHPM_MAX_COUNTERS; k++) begin
            if (k < num_counters) begin
                mask[k + CSR_MHPM_FIRST_IDX] = 1'b1;
            end else begin
                mask[k + CSR_MHPM_FIRST_IDX] = 1'b0;
            end
        end
        return mask;
    endfunction

    function automatic logic is_implemented(input int unsigned idx, input int unsigned num_counters);
        return (idx == 0) || (idx == 2) ||
               ((idx >= CSR_MHPM_FIRST_IDX) && (idx < CSR_MHPM_FIRST_IDX + num_counters));
    endfunction

endpackage

// File: rtl/cve2_hpm_counter_unit_if.sv
// CSR access channel between the CSR file (master) and the counter unit (slave).
interface cve2_hpm_counter_unit_if;
    logic        csr_access_i;
    logic        csr_we_i;
    logic [11:0] csr_addr_i;
    logic [31:0] csr_wdata_i;
    logic [31:0] csr_rdata_o;
    logic        csr_hit_o;

    modport master (
        output csr_access_i, csr_we_i, csr_addr_i, csr_wdata_i,
        input  csr_rdata_o, csr_hit_o
    );

    modport slave (
        input  csr_access_i, csr_we_i, csr_addr_i, csr_wdata_i,
        output csr_rdata_o, csr_hit_o
    );
endinterface

// File: rtl/cve2_hpm_counter_unit_counter.sv
// Single up-counter of configurable width, presented as a zero-extended 64-bit value.
// A CSR write to either half wins over the increment in the same cycle.
module cve2_counter #(
    parameter int unsigned Width = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        inc,
    input  logic        we_lo,
    input  logic        we_hi,
    input  logic [31:0] wdata,
    output logic [63:0] value
);

    localparam logic [63:0] Mask = (Width >= 64) ? {64{1'b1}} : ((64'd1 << Width) - 64'd1);
    localparam logic        HasHigh = (Width > 32);

    logic [63:0] cnt_r;
    logic [63:0] cnt_nxt_s;
    logic [63:0] wr_val_s;
    logic        we_hi_s;

    assign we_hi_s = we_hi & HasHigh;

    // Next-value selection: write merge, masked increment, or hold.
    always_comb begin
        wr_val_s = cnt_r;
        if (we_lo) begin
            wr_val_s[31:0] = wdata;
        end else begin
            wr_val_s[31:0] = cnt_r[31:0];
        end
        if (we_hi_s) begin
            wr_val_s[63:32] = wdata;
        end else begin
            wr_val_s[63:32] = cnt_r[63:32];
        end

        if (we_lo | we_hi_s) begin
            cnt_nxt_s = wr_val_s & Mask;
        end else if (inc) begin
            cnt_nxt_s = (cnt_r + 64'd1) & Mask;
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Counter state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_r <= 64'h0;
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    assign value = cnt_r;

endmodule

// File: rtl/cve2_hpm_counter_unit.sv
// Machine counter/timer unit: mcycle, minstret, mhpmcounter3..N, mhpmevent3..N, mcountinhibit.
// Event selectors are masks over event_i; any selected event in a cycle adds exactly one.
module cve2_hpm_counter_unit
    import cve2_hpm_counter_unit_pkg::*;
#(
    parameter int unsigned NumCounters  = 8,
    parameter int unsigned CounterWidth = 40,
    parameter int unsigned NumEvents    = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    cve2_hpm_counter_unit_if.slave   csr,
    input  logic                     instr_ret_i,
    input  logic [NumEvents-1:0]     event_i,
    input  logic                     debug_mode_i,
    input  logic                     dcsr_stopcount_i
);

    localparam int unsigned NumSlots = (NumCounters > 0) ? NumCounters : 1;
    localparam logic [31:0] InhMask  = inhibit_mask(NumCounters);

    logic [4:0]           idx_s;
    logic                 sel_evt_s;
    logic                 sel_lo_s;
    logic                 sel_hi_s;
    logic                 wr_s;
    logic                 freeze_s;
    logic                 hit_s;
    logic [31:0]          rdata_s;
    logic [31:0]          inhibit_r;
    logic [NumEvents-1:0] event_sel_r [NumSlots];
    logic [63:0]          cnt_val_s   [32];
    logic [31:0]          evt_val_s   [32];

    assign idx_s     = csr.csr_addr_i[4:0];
    assign sel_evt_s = csr.csr_access_i & (csr.csr_addr_i[11:5] == CSR_PAGE_EVT);
    assign sel_lo_s  = csr.csr_access_i & (csr.csr_addr_i[11:5] == CSR_PAGE_CNT_LO);
    assign sel_hi_s  = csr.csr_access_i & (csr.csr_addr_i[11:5] == CSR_PAGE_CNT_HI);
    assign wr_s      = csr.csr_access_i & csr.csr_we_i;
    assign freeze_s  = debug_mode_i & dcsr_stopcount_i;

    // mcountinhibit register; unimplemented bits are masked on write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inhibit_r <= 32'h0;
        end else if (wr_s && sel_evt_s && (idx_s == 5'd0)) begin
            inhibit_r <= csr.csr_wdata_i & InhMask;
        end else begin
            inhibit_r <= inhibit_r;
        end
    end

    // mhpmevent selector masks, one per implemented counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned j = 0; j < NumSlots; j++) begin
                event_sel_r[j] <= {NumEvents{1'b0}};
            end
        end else begin
            for (int unsigned j = 0; j < NumSlots; j++) begin
                if (wr_s && sel_evt_s && (j < NumCounters) && (idx_s == 5'(j + CSR_MHPM_FIRST_IDX))) begin
                    event_sel_r[j] <= csr.csr_wdata_i[NumEvents-1:0];
                end else begin
                    event_sel_r[j] <= event_sel_r[j];
                end
            end
        end
    end

    for (genvar i = 0; i < 32; i++) begin : g_slot
        if (is_implemented(i, NumCounters)) begin : g_cnt
            localparam int unsigned W = (i < 3) ? 64 : CounterWidth;
            logic inc_s;
            if (i == 0) begin : g_mcycle
                assign inc_s = ~inhibit_r[i] & ~freeze_s;
            end else if (i == 2) begin : g_minstret
                assign inc_s = instr_ret_i & ~inhibit_r[i] & ~freeze_s;
            end else begin : g_hpm
                assign inc_s = (|(event_sel_r[i-3] & event_i)) & ~inhibit_r[i] & ~freeze_s;
            end

            cve2_counter #(
                .Width (W)
            ) u_counter (
                .clk_i  (clk_i),
                .rst_ni (rst_ni),
                .inc    (inc_s),
                .we_lo  (wr_s & sel_lo_s & (idx_s == 5'(i))),
                .we_hi  (wr_s & sel_hi_s & (idx_s == 5'(i))),
                .wdata  (csr.csr_wdata_i),
                .value  (cnt_val_s[i])
            );
        end else begin : g_no_cnt
            assign cnt_val_s[i] = 64'h0;
        end

        if ((i >= 3) && is_implemented(i, NumCounters)) begin : g_evt
            assign evt_val_s[i] = 32'(event_sel_r[i-3]);
        end else begin : g_no_evt
            assign evt_val_s[i] = 32'h0;
        end
    end

    // Read-data mux; unimplemented entries already contribute zero.
    always_comb begin
        rdata_s = 32'h0;
        if (sel_evt_s) begin
            if (idx_s == 5'd0) begin
                rdata_s = inhibit_r;
            end else begin
                rdata_s = evt_val_s[idx_s];
            end
        end else if (sel_lo_s) begin
            rdata_s = cnt_val_s[idx_s][31:0];
        end else if (sel_hi_s) begin
            rdata_s = cnt_val_s[idx_s][63:32];
        end else begin
            rdata_s = 32'h0;
        end
    end

    // 0x321/0x322 sit in the event page but belong to someone else.
    assign hit_s = sel_lo_s | sel_hi_s | (sel_evt_s & (idx_s != 5'd1) & (idx_s != 5'd2));

    assign csr.csr_rdata_o = rdata_s;
    assign csr.csr_hit_o   = hit_s;

endmodule

// File: tb/tb_cve2_hpm_counter_unit.sv
// Randomised and directed bench for cve2_hpm_counter_unit against a CSR-level counter model.
module tb_cve2_hpm_counter_unit;

    localparam int NUM_CNT = 8;
    localparam int CNT_W   = 40;
    localparam int NUM_EVT = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               instr_ret = 1'b0;
    logic [NUM_EVT-1:0] ev = '0;
    logic               dbg = 1'b0;
    logic               stop = 1'b0;

    cve2_hpm_counter_unit_if csr_if ();

    cve2_hpm_counter_unit #(
        .NumCounters  (NUM_CNT),
        .CounterWidth (CNT_W),
        .NumEvents    (NUM_EVT)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .csr              (csr_if),
        .instr_ret_i      (instr_ret),
        .event_i          (ev),
        .debug_mode_i     (dbg),
        .dcsr_stopcount_i (stop)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model state indexed by CSR counter index 0..31.
    bit [63:0] m_cnt [32];
    bit [15:0] m_evt [32];
    bit [31:0] m_inh;

    logic [11:0] addr_pool [21] = '{12'hB00, 12'hB02, 12'hB03, 12'hB04, 12'hB0A, 12'hB0B, 12'hB01,
                                    12'hB80, 12'hB82, 12'hB83, 12'hB8A, 12'h320, 12'h323, 12'h324,
                                    12'h32A, 12'h32B, 12'h321, 12'h33F, 12'hB1F, 12'h000, 12'hB9F};

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic bit impl(input int i);
        return (i == 0) || (i == 2) || (i >= 3 && i < 3 + NUM_CNT);
    endfunction

    function automatic bit [63:0] cnt_mask(input int i);
        int w;
        w = (i < 3) ? 64 : CNT_W;
        return (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 32; k++) begin
            m_cnt[k] = 64'h0;
            m_evt[k] = 16'h0;
        end
        m_inh = 32'h0;
    endtask

    function automatic logic [31:0] exp_rdata();
        logic [11:0] a;
        int          i;
        a = csr_if.csr_addr_i;
        i = int'(a[4:0]);
        if (!csr_if.csr_access_i) return 32'h0;
        if (a == 12'h320) return m_inh;
        if (a >= 12'h323 && a <= 12'h33F) return impl(i) ? 32'(m_evt[i]) : 32'h0;
        if (a >= 12'hB00 && a <= 12'hB1F) return impl(i) ? m_cnt[i][31:0] : 32'h0;
        if (a >= 12'hB80 && a <= 12'hB9F) return impl(i) ? m_cnt[i][63:32] : 32'h0;
        return 32'h0;
    endfunction

    function automatic logic exp_hit();
        logic [11:0] a;
        a = csr_if.csr_addr_i;
        if (!csr_if.csr_access_i) return 1'b0;
        return (a == 12'h320) || (a >= 12'h323 && a <= 12'h33F) ||
               (a >= 12'hB00 && a <= 12'hB1F) || (a >= 12'hB80 && a <= 12'hB9F);
    endfunction

    // One clock edge of the architectural counter rules, using the inputs held across it.
    task automatic model_step();
        bit          frz, wr, cond;
        logic [11:0] a;
        logic [31:0] wd;
        if (!rst_n) begin
            model_clear();
            return;
        end
        frz = dbg & stop;
        wr  = csr_if.csr_access_i & csr_if.csr_we_i;
        a   = csr_if.csr_addr_i;
        wd  = csr_if.csr_wdata_i;
        for (int k = 0; k < 32; k++) begin
            if (impl(k)) begin
                if (k == 0)      cond = 1'b1;
                else if (k == 2) cond = instr_ret;
                else             cond = |(m_evt[k] & ev);
                if (wr && a == 12'(12'hB00 + k))
                    m_cnt[k] = {m_cnt[k][63:32], wd} & cnt_mask(k);
                else if (wr && a == 12'(12'hB80 + k) && (k < 3 || CNT_W > 32))
                    m_cnt[k] = {wd, m_cnt[k][31:0]} & cnt_mask(k);
                else if (!frz && !m_inh[k] && cond)
                    m_cnt[k] = (m_cnt[k] + 64'd1) & cnt_mask(k);
            end
        end
        if (wr && a == 12'h320) m_inh = wd & 32'h0000_07FD;
        if (wr && a >= 12'h323 && a <= 12'h33F && impl(int'(a[4:0]))) m_evt[a[4:0]] = wd[15:0];
    endtask

    // Compare outputs mid-cycle, then advance one clock; always returns at a negedge.
    task automatic tick();
        #1;
        check_eq("rdata", csr_if.csr_rdata_o, exp_rdata());
        check_eq("hit", 32'(csr_if.csr_hit_o), 32'(exp_hit()));
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        csr_if.csr_access_i = 1'b1;
        csr_if.csr_we_i     = 1'b1;
        csr_if.csr_addr_i   = a;
        csr_if.csr_wdata_i  = d;
        tick();
        csr_if.csr_access_i = 1'b0;
        csr_if.csr_we_i     = 1'b0;
    endtask

    task automatic rd_exp(input string tag, input logic [11:0] a, input logic [31:0] exp);
        csr_if.csr_access_i = 1'b1;
        csr_if.csr_we_i     = 1'b0;
        csr_if.csr_addr_i   = a;
        #1;
        check_eq(tag, csr_if.csr_rdata_o, exp);
        tick();
        csr_if.csr_access_i = 1'b0;
    endtask

    task automatic probe_hit(input string tag, input logic [11:0] a, input logic exp);
        csr_if.csr_access_i = 1'b1;
        csr_if.csr_we_i     = 1'b0;
        csr_if.csr_addr_i   = a;
        #1;
        check_eq(tag, 32'(csr_if.csr_hit_o), 32'(exp));
        tick();
        csr_if.csr_access_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        rd_exp("reset_mcycle", 12'hB00, 32'h0);
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        csr_if.csr_access_i = 1'b0;
        csr_if.csr_we_i     = 1'b0;
        csr_if.csr_addr_i   = 12'h0;
        csr_if.csr_wdata_i  = 32'h0;
        model_clear();
        @(negedge clk);
        #1;
        check_eq("reset_rdata_idle", csr_if.csr_rdata_o, 32'h0);
        check_eq("reset_hit_idle", 32'(csr_if.csr_hit_o), 32'h0);
        @(negedge clk);
        do_reset();

        repeat (10) tick();
        rd_exp("mcycle_idle10", 12'hB00, 32'd10);
        rd_exp("minstret_idle", 12'hB02, 32'd0);
        rd_exp("hpm3_idle", 12'hB03, 32'd0);
        rd_exp("hpm4h_idle", 12'hB84, 32'd0);

        wr(12'h323, 32'h0000_0003);
        rd_exp("mhpmevent3", 12'h323, 32'h0000_0003);
        ev = 16'h0003;
        repeat (5) tick();
        ev = 16'h0000;
        rd_exp("hpm3_multi_evt", 12'hB03, 32'd5);

        wr(12'hB83, 32'h0000_00FF);
        wr(12'hB03, 32'hFFFF_FFFF);
        ev = 16'h0001;
        tick();
        ev = 16'h0000;
        rd_exp("hpm3_wrap_lo", 12'hB03, 32'h0);
        rd_exp("hpm3_wrap_hi", 12'hB83, 32'h0);
        wr(12'hB83, 32'hFFFF_FFFF);
        rd_exp("hpm3h_width", 12'hB83, 32'h0000_00FF);

        rd_exp("mcycleh_before", 12'hB80, 32'h0);
        wr(12'hB00, 32'h0000_0100);
        rd_exp("mcycle_write", 12'hB00, 32'h0000_0100);
        rd_exp("mcycle_after_wr", 12'hB00, 32'h0000_0101);
        rd_exp("mcycleh_hold", 12'hB80, 32'h0);

        wr(12'h320, 32'hFFFF_FFFF);
        rd_exp("inhibit_readback", 12'h320, 32'h0000_07FD);
        instr_ret = 1'b1;
        for (int n = 0; n < 20; n++) begin
            ev = NUM_EVT'($urandom);
            tick();
        end
        instr_ret = 1'b0;
        ev = '0;
        rd_exp("inhibit_mcycle", 12'hB00, 32'h0000_0104);
        rd_exp("inhibit_minstret", 12'hB02, 32'h0);
        rd_exp("inhibit_hpm3", 12'hB03, 32'h0);
        wr(12'h320, 32'h0);

        dbg  = 1'b1;
        stop = 1'b1;
        repeat (7) tick();
        rd_exp("dbg_stopcount", 12'hB00, 32'h0000_0104);
        stop = 1'b0;
        repeat (7) tick();
        rd_exp("dbg_no_stop", 12'hB00, 32'h0000_010B);
        dbg = 1'b0;

        probe_hit("hit_unimpl_b0f", 12'hB0F, 1'b1);
        wr(12'hB0F, 32'h1234_5678);
        rd_exp("unimpl_b0f", 12'hB0F, 32'h0);
        probe_hit("hit_321", 12'h321, 1'b0);
        probe_hit("hit_b01", 12'hB01, 1'b1);

        for (int n = 0; n < 400; n++) begin
            if (n == 200) begin
                do_reset();
            end
            csr_if.csr_access_i = ($urandom_range(0, 2) != 0);
            csr_if.csr_we_i     = ($urandom_range(0, 7) == 0);
            csr_if.csr_addr_i   = addr_pool[$urandom_range(0, 20)];
            csr_if.csr_wdata_i  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            instr_ret           = 1'($urandom_range(0, 1));
            ev                  = NUM_EVT'($urandom) & NUM_EVT'($urandom);
            dbg                 = ($urandom_range(0, 7) == 0);
            stop                = 1'($urandom_range(0, 1));
            tick();
        end
        csr_if.csr_access_i = 1'b0;
        csr_if.csr_we_i     = 1'b0;
        dbg = 1'b0;
        rd_exp("final_minstret", 12'hB02, m_cnt[2][31:0]);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
